// File: rtl/intc_pkg.sv
// Shared types and defaults for the interrupt controller.
package intc_pkg;

  localparam int unsigned N_SRC_DEF = 4;
  localparam int unsigned VEC_W_DEF = 10;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  // Index width that stays legal for a single source
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: idx names the lowest set request bit.
module prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is written last
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Multi-source interrupt controller: edge capture, pending/mask registers,
// fixed-priority selection and the entry/service handshake with the control unit.
module interrupt_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC      = N_SRC_DEF,
  parameter int unsigned VEC_W      = VEC_W_DEF,
  parameter int unsigned VEC_BASE   = 'h3C0,
  parameter int unsigned VEC_STRIDE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             fin_interrup,
  output logic             s_interrup,
  output logic [VEC_W-1:0] vector,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  localparam int unsigned IDX_W = idx_width(N_SRC);

  logic [N_SRC-1:0] r_irq_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  intc_state_e      r_state;
  logic [IDX_W-1:0] r_cur_idx;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic             w_grant;
  logic [VEC_W-1:0] w_vec;

  assign w_rise  = irq & ~r_irq_q;
  assign w_elig  = r_pending & r_mask;
  assign w_grant = (r_state == ST_IDLE) && w_any;

  prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req (w_elig),
    .any (w_any),
    .idx (w_idx)
  );

  // One-hot clear of the granted pending bit
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_clr[i] = w_grant && (w_idx == IDX_W'(i));
    end
  end

  // Edge detector history and pending bits; a new edge beats the grant clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irq_q   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  // Enable mask written by software
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_in;
    end
  end

  // Entry sequencing: one ENTER cycle, then hold in SERVICE until end-of-interrupt
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state   <= ST_ENTER;
            r_cur_idx <= w_idx;
          end
        end
        ST_ENTER: begin
          r_state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (fin_interrup) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handler address wraps modulo 2^VEC_W by construction of the operand widths
  assign w_vec = VEC_W'(VEC_BASE) + VEC_W'(r_cur_idx) * VEC_W'(VEC_STRIDE);

  // Outputs decode only registered state, never the inputs
  assign s_interrup = (r_state == ST_ENTER);
  assign vector     = (r_state == ST_ENTER) ? w_vec : '0;
  assign busy       = (r_state != ST_IDLE);
  assign pending    = r_pending;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios then random traffic,
// all compared against a transaction-level reference model.
module tb_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       fin_interrup;
  logic       s_interrup;
  logic [9:0] vector;
  logic       busy;
  logic [3:0] pending;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pending set, mask, which phase of the handshake we are in
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [3:0] m_prev;
  int         m_phase;  // 0 idle, 1 entering, 2 servicing
  int         m_idx;

  interrupt_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq          (irq),
    .mask_we      (mask_we),
    .mask_in      (mask_in),
    .fin_interrup (fin_interrup),
    .s_interrup   (s_interrup),
    .vector       (vector),
    .busy         (busy),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic [3:0] iv, input logic mwe,
                            input logic [3:0] mv, input logic fin);
    int win;
    if (!rn) begin
      m_pend  = '0;
      m_mask  = '0;
      m_prev  = '0;
      m_phase = 0;
      m_idx   = 0;
    end else begin
      if (m_phase == 0) begin
        win = -1;
        for (int i = 3; i >= 0; i--) begin
          if (m_pend[i] && m_mask[i]) win = i;
        end
        if (win >= 0) begin
          m_pend[win] = 1'b0;
          m_idx       = win;
          m_phase     = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (fin) begin
        m_phase = 0;
      end
      m_pend = m_pend | (iv & ~m_prev);
      if (mwe) m_mask = mv;
      m_prev = iv;
    end
  endtask

  task automatic check_model();
    int exp_vec;
    exp_vec = (m_phase == 1) ? ((32'h3C0 + m_idx * 16) % 1024) : 0;
    chk("s_interrup", 32'(s_interrup), (m_phase == 1) ? 32'd1 : 32'd0);
    chk("vector", 32'(vector), exp_vec);
    chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step(input logic rn, input logic [3:0] iv, input logic mwe,
                      input logic [3:0] mv, input logic fin);
    reset_n      = rn;
    irq          = iv;
    mask_we      = mwe;
    mask_in      = mv;
    fin_interrup = fin;
    @(posedge clk);
    model_edge(rn, iv, mwe, mv, fin);
    #1;
    check_model();
  endtask

  task automatic go(input logic [3:0] iv);
    step(1'b1, iv, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic fin();
    step(1'b1, 4'h0, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    m_pend = '0; m_mask = '0; m_prev = '0; m_phase = 0; m_idx = 0;
    // Reset
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_vector", 32'(vector), 32'h0);

    // Pending latched while masked, then unmask
    go(4'b0001);
    go(4'b0000);
    chk("masked_pend", 32'(pending), 32'b0001);
    chk("masked_no_s", 32'(s_interrup), 32'h0);
    step(1'b1, 4'h0, 1'b1, 4'b1111, 1'b0);
    chk("mask_edge_no_s", 32'(s_interrup), 32'h0);
    go(4'b0000);
    chk("unmask_s", 32'(s_interrup), 32'h1);
    chk("unmask_vec", 32'(vector), 32'h3C0);
    go(4'b0000);
    chk("enter_one_cycle", 32'(s_interrup), 32'h0);
    fin();

    // Two simultaneous edges: lower index first, idle gap, then the other
    go(4'b1010);
    go(4'b0000);
    chk("pri_vec1", 32'(vector), 32'h3D0);
    go(4'b0000);
    fin();
    chk("gap_idle", 32'(busy), 32'h0);
    go(4'b0000);
    chk("pri_vec3", 32'(vector), 32'h3F0);
    go(4'b0000);
    fin();

    // No preemption during service
    go(4'b0100);
    go(4'b0000);
    chk("src2_vec", 32'(vector), 32'h3E0);
    go(4'b0000);
    go(4'b0001);
    go(4'b0000);
    chk("no_preempt", 32'(s_interrup), 32'h0);
    fin();
    go(4'b0000);
    chk("after_fin_vec0", 32'(vector), 32'h3C0);
    go(4'b0000);
    fin();

    // Held level gives a single entry
    go(4'b0010);
    go(4'b0010);
    go(4'b0010);
    step(1'b1, 4'b0010, 1'b0, 4'h0, 1'b1);
    go(4'b0010);
    go(4'b0010);
    chk("level_no_repend", 32'(pending), 32'h0);
    chk("level_no_s", 32'(s_interrup), 32'h0);
    go(4'b0000);
    go(4'b0010);
    go(4'b0010);
    chk("level_reedge", 32'(s_interrup), 32'h1);
    go(4'b0000);
    fin();

    // New edge in the grant cycle: set wins, served twice
    step(1'b1, 4'h0, 1'b1, 4'b1110, 1'b0);
    go(4'b0001);
    go(4'b0000);
    step(1'b1, 4'h0, 1'b1, 4'b1111, 1'b0);
    go(4'b0001);
    chk("setwin_s", 32'(s_interrup), 32'h1);
    chk("setwin_pend", 32'(pending), 32'b0001);
    go(4'b0000);
    fin();
    go(4'b0000);
    chk("setwin_again", 32'(vector), 32'h3C0);
    go(4'b0000);
    fin();

    // Reset mid-service
    go(4'b0100);
    go(4'b0000);
    go(4'b0000);
    go(4'b0100);
    chk("pre_rst_pend", 32'(pending), 32'b0100);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("midrst_pend", 32'(pending), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    go(4'b0001);
    go(4'b0000);
    go(4'b0000);
    chk("midrst_mask0", 32'(s_interrup), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 149) != 0),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
